// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
// Opcode encodings, FSM state enum and a carry-qualifier helper.
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } arb_state_t;

    // Only arithmetic ops produce a meaningful carry/borrow.
    function automatic logic op_has_carry(input logic [1:0] op);
        logic r;
        unique case (op)
            OP_ADD, OP_SUB: r = 1'b1;
            OP_AND, OP_OR:  r = 1'b0;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-valid search starting at ptr_i.
// Ports: valid_i (request vector), ptr_i (start index), grant_o (one-hot), idx_o.
module rr_picker
    import alu_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        logic          found;
        logic [IW-1:0] j;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered serial ALU among N_REQ requesters: round-robin grant,
// operand issue, result capture with corrected flags, tagged valid/ready response.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_a/req_b/req_op
// per requester (packed); alu_a/alu_b/alu_op to ALU, alu_result/alu_carry back;
// rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_carry/rsp_zero; busy.
// Option: ALU_ARB_PRIO0_EN gives requester 0 absolute priority.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    input  logic [N_REQ*2-1:0]       req_op,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [1:0]               alu_op,
    input  logic [W-1:0]             alu_result,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]             rsp_result,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  res_q, res_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;

    logic [N_REQ-1:0] pick_valid;
    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             any_req;
    logic [IW:0]      id_inc;
    logic [IW-1:0]    ptr_next;
    logic             ptr_adv;

    assign any_req = |req_valid;

`ifdef ALU_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation; the pointer only orders 1..N-1.
    assign pick_valid = {req_valid[N_REQ-1:1], 1'b0};
    assign grant      = req_valid[0] ? N_REQ'(1) : pick_grant;
    assign grant_idx  = req_valid[0] ? '0 : pick_idx;
    assign ptr_adv    = (id_q != '0);
`else
    assign pick_valid = req_valid;
    assign grant      = pick_grant;
    assign grant_idx  = pick_idx;
    assign ptr_adv    = 1'b1;
`endif

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .valid_i (pick_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // (g+1) mod N_REQ without relying on N_REQ being a power of two.
    assign id_inc   = {1'b0, id_q} + {{IW{1'b0}}, 1'b1};
    assign ptr_next = (id_inc >= (IW+1)'(N_REQ)) ? '0 : id_inc[IW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        req_ready = '0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    a_d       = req_a[int'(grant_idx)*W +: W];
                    b_d       = req_b[int'(grant_idx)*W +: W];
                    op_d      = req_op[int'(grant_idx)*2 +: 2];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Zero is derived here; the ALU's own zero flag is stale.
                res_d   = alu_result;
                carry_d = alu_carry & op_has_carry(op_q);
                zero_d  = (alu_result == '0);
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (ptr_adv) begin
                        ptr_d = ptr_next;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Controller that shares one registered 4-bit serial ALU among `N_REQ` requesters. It arbitrates operation requests round-robin and drives the ALU operand/opcode inputs. It captures the ALU result one cycle later, computes correct flags, and returns a tagged response over a valid/ready handshake. It sits between the requesting engines and the single ALU instance, which it owns exclusively.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 4: operand width; must equal the ALU width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_ready` out `N_REQ`: per-requester accept; one-hot or zero.
- `req_a` in `N_REQ*W`: operand A, packed, requester i at `[i*W +: W]`.
- `req_b` in `N_REQ*W`: operand B, packed the same way.
- `req_op` in `N_REQ*2`: opcode, packed `[i*2 +: 2]`. Encoding: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `alu_a` out W: operand A to the ALU.
- `alu_b` out W: operand B to the ALU.
- `alu_op` out 2: opcode to the ALU.
- `alu_result` in W: registered result from the ALU.
- `alu_carry` in 1: registered carry from the ALU.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out `$clog2(N_REQ)`: index of the served requester.
- `rsp_result` out W: operation result.
- `rsp_carry` out 1: carry/borrow; forced to 0 for AND/OR.
- `rsp_zero` out 1: 1 iff `rsp_result` == 0.
- `busy` out 1: high in any state other than IDLE.

## Operation
FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE:** if any `req_valid` is high, the picker selects grant g. g is the first valid index at or after `rr_ptr`, wrapping. `req_ready[g]` is asserted combinationally in the same cycle. On that edge:
  - latch `req_a[g]`, `req_b[g]`, `req_op[g]` and g;
  - go to ISSUE.
  If no request is valid, stay in IDLE.
- **ISSUE:** `alu_a`, `alu_b` and `alu_op` are driven from the latched registers. These outputs are registered and held stable until the next grant. The ALU samples at the end of this cycle. Go to CAPTURE.
- **CAPTURE:** `alu_result` and `alu_carry` are valid. On the edge:
  - latch `rsp_result` = `alu_result`;
  - latch `rsp_carry` = `alu_carry` if the op is ADD/SUB, else 0;
  - latch `rsp_zero` = (`alu_result` == 0).
  The ALU's own zero flag lags by one operation and is never used. Go to RESP.
- **RESP:** `rsp_valid` = 1 and all `rsp_*` are held stable. When `rsp_ready` is high:
  - `rr_ptr` ← (g+1) mod `N_REQ`;
  - go to IDLE.
- A requester must hold its valid and operands stable until its `req_ready`.
- `req_valid` changes while the controller is not in IDLE have no effect.
- Arithmetic: SUB borrow is bit W of the (W+1)-bit A−B. For example, 3−5 gives result 14 and carry 1.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` = 0;
  - all `req_ready` 0, `rsp_valid` 0;
  - `rsp_id`, `rsp_result`, `rsp_carry`, `rsp_zero` all 0;
  - `alu_a`, `alu_b`, `alu_op` all 0;
  - `busy` 0.
- Latency: for a request accepted in cycle T, `rsp_valid` rises in cycle T+3.
- Minimum spacing between accepts is 4 cycles, achieved when `rsp_ready` is tied high.
- Back-to-back: the cycle after the RESP handshake is IDLE and may grant immediately.
- Backpressure: with `rsp_ready` low, RESP persists indefinitely. No new request is accepted and the ALU inputs are unchanged.
- Reset mid-operation, in any state: the operation is abandoned with no response, and all registers return to their reset values.
- When only one requester is valid, it wins regardless of `rr_ptr`.

## Configuration
- `ALU_ARB_PRIO0_EN` defined: requester 0 has absolute priority and wins whenever `req_valid[0]` is high. `rr_ptr` governs only indices 1..`N_REQ`−1 and never advances because of a grant to 0.
- Not defined: pure round-robin over all requesters.

## Structure
- Package `alu_arb_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`;
  - the FSM state enum `arb_state_t`.
- Sub-module `rr_picker`: combinational round-robin first-valid search. Inputs are the valid vector and the pointer; outputs are a one-hot grant and an index.
- The FSM, operand/response registers and `rr_ptr` are in the top level.

## Test plan
- Single ADD: req0 A=9, B=8 → `rsp_id` 0, result 1, carry 1, zero 0. `rsp_valid` 3 cycles after accept.
- SUB: req2 A=3, B=5 → result 14, carry 1, `rsp_id` 2.
- AND after an ADD with carry: A=0xA, B=0x5 → result 0, zero 1, carry 0.
- All 4 requesters held valid, `rsp_ready` high → grant order 0,1,2,3,0, each accept 4 cycles apart. With `ALU_ARB_PRIO0_EN` → order 0,0,0…
- Backpressure: `rsp_ready` low for 5 cycles in RESP → `rsp_*` and `alu_*` stable, `req_ready` all 0. Accepted on the 6th cycle.
- Reset asserted in CAPTURE → no response, all outputs 0 next cycle. A subsequent request from req1 is granted first (`rr_ptr` = 0, req0 idle).
